gf_mat_vec_mul_stream: RTL and testbench

GF_MAT_VEC_MUL_STREAM -- requirements
Module: gf_mat_vec_mul_stream

---
 rtl/gf_mat_vec_mul_stream.sv | 170 +++++++++++++++++
 tb/tb_gf_mat_vec_mul_stream.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_mat_vec_mul_stream.sv
// GF(2^8) matrix-vector multiply over beat streams: y = M*x (or y0 ^ M*x), one byte per row.
// Latency 1 cycle from a row's last matrix beat to o_res_valid; matrix stalls only on a full, unconsumed result.
module gf_mat_vec_mul_stream #(
    parameter int MAT_ROWS  = 8,
    parameter int MAT_COLS  = 8,
    parameter int N_GF      = 8,
    parameter int PROC_SIZE = N_GF*8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_acc_en,
    input  logic [PROC_SIZE-1:0] i_vec,
    input  logic                 i_vec_valid,
    output logic                 o_vec_ready,
    input  logic [PROC_SIZE-1:0] i_mat,
    input  logic                 i_mat_valid,
    output logic                 o_mat_ready,
    input  logic [7:0]           i_y0,
    output logic [7:0]           o_res,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic                 o_res_last,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int BEATS = MAT_COLS / N_GF;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = (MAT_ROWS > 1) ? $clog2(MAT_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_VEC, MAT, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [PROC_SIZE-1:0] vbuf_q [2**BW];
    logic [BW-1:0]        vcnt_q, vcnt_d, col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 acc_mode_q, acc_mode_d;
    logic [7:0]           acc_q, acc_d, res_q, res_d;
    logic                 res_vld_q, res_vld_d, res_last_q, res_last_d;
    logic                 vec_we, mat_rdy, first_beat, last_beat, last_row, res_fire;
    logic [7:0]           partial, sum;

    // Shift-and-add multiply, reducing by 0x11B as each doubling overflows.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    always_comb begin
        partial = 8'h00;
        for (int j = 0; j < N_GF; j++) begin
            partial = partial ^ gf_mul(i_mat[PROC_SIZE-1-8*j -: 8], vbuf_q[col_q][PROC_SIZE-1-8*j -: 8]);
        end
    end

    always_comb begin
        state_d     = state_q;
        vcnt_d      = vcnt_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_mode_d  = acc_mode_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_vld_d   = res_vld_q;
        res_last_d  = res_last_q;
        vec_we      = 1'b0;
        mat_rdy     = 1'b0;
        o_vec_ready = 1'b0;
        o_done      = 1'b0;
        first_beat  = (col_q == '0);
        last_beat   = (col_q == BW'(BEATS-1));
        last_row    = (row_q == RW'(MAT_ROWS-1));
        sum         = (first_beat ? (acc_mode_q ? i_y0 : 8'h00) : acc_q) ^ partial;
        res_fire    = res_vld_q && i_res_ready;

        if (res_fire) begin
            res_vld_d  = 1'b0;
            res_last_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = LOAD_VEC;
                    acc_mode_d = i_acc_en;
                end
            end
            LOAD_VEC: begin
                o_vec_ready = 1'b1;
                if (i_vec_valid) begin
                    vec_we = 1'b1;
                    if (vcnt_q == BW'(BEATS-1)) begin
                        vcnt_d  = '0;
                        state_d = MAT;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            MAT: begin
                // A row-ending beat needs somewhere to put its result.
                mat_rdy = !(res_vld_q && !i_res_ready && last_beat);
                if (i_mat_valid && mat_rdy) begin
                    acc_d = sum;
                    if (last_beat) begin
                        col_d      = '0;
                        res_d      = sum;
                        res_vld_d  = 1'b1;
                        res_last_d = last_row;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (res_fire && res_last_q) begin
                    state_d = IDLE;
                    o_done  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            vcnt_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            acc_mode_q <= 1'b0;
            acc_q      <= 8'h00;
            res_q      <= 8'h00;
            res_vld_q  <= 1'b0;
            res_last_q <= 1'b0;
            for (int k = 0; k < 2**BW; k++) vbuf_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            vcnt_q     <= vcnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            acc_mode_q <= acc_mode_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
            res_last_q <= res_last_d;
            if (vec_we) vbuf_q[vcnt_q] <= i_vec;
        end
    end

    assign o_mat_ready = mat_rdy;
    assign o_res       = res_q;
    assign o_res_valid = res_vld_q;
    assign o_res_last  = res_last_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gf_mat_vec_mul_stream.sv
// Randomized bench for gf_mat_vec_mul_stream against a polynomial-division GF(2^8) model.
module tb_gf_mat_vec_mul_stream;
    localparam int R = 8;
    localparam int C = 8;
    localparam int N = 8;
    localparam int P = N*8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start, i_acc_en;
    logic [P-1:0] i_vec, i_mat;
    logic         i_vec_valid, i_mat_valid, i_res_ready;
    logic [7:0]   i_y0;
    logic         o_vec_ready, o_mat_ready, o_res_valid, o_res_last, o_busy, o_done;
    logic [7:0]   o_res;

    logic [7:0] x  [C];
    logic [7:0] m  [R][C];
    logic [7:0] y0 [R];

    int checks = 0;
    int failures = 0;

    gf_mat_vec_mul_stream #(.MAT_ROWS(R), .MAT_COLS(C), .N_GF(N), .PROC_SIZE(P)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_acc_en(i_acc_en),
        .i_vec(i_vec), .i_vec_valid(i_vec_valid), .o_vec_ready(o_vec_ready),
        .i_mat(i_mat), .i_mat_valid(i_mat_valid), .o_mat_ready(o_mat_ready),
        .i_y0(i_y0), .o_res(o_res), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_last(o_res_last), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Carry-less product, then long division by the field polynomial.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i-8));
        return p[7:0];
    endfunction

    function automatic logic [P-1:0] pack_x();
        logic [P-1:0] v;
        for (int j = 0; j < C; j++) v[P-1-8*j -: 8] = x[j];
        return v;
    endfunction

    function automatic logic [P-1:0] pack_row(input int r);
        logic [P-1:0] v;
        for (int j = 0; j < C; j++) v[P-1-8*j -: 8] = m[r][j];
        return v;
    endfunction

    task automatic idle_inputs();
        i_start = 1'b0; i_acc_en = 1'b0; i_vec = '0; i_mat = '0;
        i_vec_valid = 1'b0; i_mat_valid = 1'b0; i_res_ready = 1'b0; i_y0 = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_res"}, o_res, 0);
        check_eq({tag, "_res_valid"}, o_res_valid, 0);
        check_eq({tag, "_res_last"}, o_res_last, 0);
        check_eq({tag, "_vec_ready"}, o_vec_ready, 0);
        check_eq({tag, "_mat_ready"}, o_mat_ready, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_done"}, o_done, 0);
    endtask

    task automatic randomize_data();
        for (int c = 0; c < C; c++) x[c] = 8'($urandom_range(0, 255));
        for (int r = 0; r < R; r++) begin
            y0[r] = 8'($urandom_range(0, 255));
            for (int c = 0; c < C; c++) m[r][c] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic set_identity();
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) m[r][c] = (r == c) ? 8'h01 : 8'h00;
        for (int c = 0; c < C; c++) x[c] = 8'(c);
    endtask

    task automatic run_op(input bit acc, input bit stall, input int rst_row, input bit extra_start);
        logic [7:0] er [R];
        int mrow, got, cyc, stall_left, done_cnt;
        bit vec_done, vf, mf, rf, prev_mf;
        logic [7:0] held;
        for (int r = 0; r < R; r++) begin
            er[r] = acc ? y0[r] : 8'h00;
            for (int c = 0; c < C; c++) er[r] = er[r] ^ ref_mul(m[r][c], x[c]);
        end
        @(negedge clk);
        i_start = 1'b1; i_acc_en = acc;
        @(negedge clk);
        i_start = 1'b0; i_acc_en = 1'($urandom_range(0, 1));
        check_eq("busy_after_start", o_busy, 1);
        mrow = 0; got = 0; cyc = 0; done_cnt = 0; vec_done = 0; prev_mf = 0;
        stall_left = stall ? 5 : 0; held = 8'h00;
        while (got < R && cyc < 1000) begin
            i_vec = pack_x();
            i_vec_valid = !vec_done && ($urandom_range(0, 3) != 0);
            if (mrow < R) begin
                i_mat = pack_row(mrow);
                i_y0  = y0[mrow];
            end
            i_mat_valid = vec_done && (mrow < R) && ($urandom_range(0, 3) != 0);
            if (stall_left > 0 && o_res_valid) i_res_ready = 1'b0;
            else i_res_ready = ($urandom_range(0, 3) != 0);
            i_start = extra_start && (cyc % 3 == 1);
            #1;
            if (vec_done && mrow == rst_row) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                i_start = 1'b0; i_vec_valid = 1'b1; i_mat_valid = 1'b1; i_res_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("postrst_res_valid", o_res_valid, 0);
                    check_eq("postrst_busy", o_busy, 0);
                    check_eq("postrst_vec_ready", o_vec_ready, 0);
                end
                idle_inputs();
                return;
            end
            if (!vec_done) check_eq("vec_ready", o_vec_ready, 1);
            if (vec_done && mrow < R) check_eq("mat_ready", o_mat_ready, !(o_res_valid && !i_res_ready));
            if (prev_mf) check_eq("res_latency", o_res_valid, 1);
            if (stall_left > 0 && o_res_valid) begin
                if (stall_left == 5) held = o_res;
                else check_eq("stall_hold", o_res, held);
                stall_left--;
            end
            vf = i_vec_valid && o_vec_ready;
            mf = i_mat_valid && o_mat_ready;
            rf = o_res_valid && i_res_ready;
            if (o_done) done_cnt++;
            if (rf) begin
                check_eq($sformatf("res_row%0d", got), o_res, er[got]);
                check_eq($sformatf("res_last_row%0d", got), o_res_last, (got == R-1));
                if (got == R-1) check_eq("done_with_last", o_done, 1);
                got++;
            end
            @(negedge clk);
            cyc++;
            prev_mf = mf;
            if (vf) vec_done = 1;
            if (mf) mrow++;
        end
        idle_inputs();
        #1;
        check_eq("results_count", got, R);
        check_eq("done_count", done_cnt, 1);
        check_eq("busy_after_done", o_busy, 0);
        check_eq("valid_after_done", o_res_valid, 0);
        repeat (2) @(negedge clk);
        check_eq("quiet_after_done", o_res_valid, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        set_identity();
        run_op(1'b0, 1'b0, -1, 1'b0);

        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) m[r][c] = 8'h00;
        for (int c = 0; c < C; c++) x[c] = 8'h00;
        m[0][0] = 8'h57; x[0] = 8'h83;
        run_op(1'b0, 1'b0, -1, 1'b0);

        set_identity();
        for (int r = 0; r < R; r++) y0[r] = 8'hFF;
        run_op(1'b1, 1'b0, -1, 1'b0);

        randomize_data();
        run_op(1'b0, 1'b1, -1, 1'b0);

        randomize_data();
        run_op(1'b1, 1'b0, -1, 1'b1);

        randomize_data();
        run_op(1'b0, 1'b0, 3, 1'b0);
        randomize_data();
        run_op(1'b1, 1'b0, -1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            randomize_data();
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
